// File: rtl/execute_pipe.sv
// Execute stage of a Y86-64 style pipeline: ALU operand select, ALU, condition
// codes, condition evaluation and the execute->memory pipeline register.
module execute_pipe #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] INOP  = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic        cc_inhibit,
  input  logic        M_bubble,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alufun;
  logic        new_zf;
  logic        new_sf;
  logic        new_of;
  logic        sxo;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      4'h2, 4'h6:       alu_a = E_valA;
      4'h3, 4'h4, 4'h5: alu_a = E_valC;
      4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       alu_a = 64'd8;
      default:          alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = E_valB;
      default:                                  alu_b = '0;
    endcase
  end

  assign alufun = (E_icode == 4'h6) ? E_ifun : 4'h0;

  always_comb begin
    e_valE = '0;
    new_of = 1'b0;
    case (alufun)
      4'h0: begin
        e_valE = alu_b + alu_a;
        new_of = (alu_a[63] == alu_b[63]) && (e_valE[63] != alu_a[63]);
      end
      4'h1: begin
        e_valE = alu_b - alu_a;
        new_of = (alu_a[63] != alu_b[63]) && (e_valE[63] != alu_b[63]);
      end
      4'h2:    e_valE = alu_b & alu_a;
      4'h3:    e_valE = alu_b ^ alu_a;
      default: e_valE = '0;
    endcase
  end

  assign new_zf = (e_valE == 64'd0);
  assign new_sf = e_valE[63];

  always_ff @(posedge clk) begin
    if (rst) begin
      ZF <= 1'b1;
      SF <= 1'b0;
      OF <= 1'b0;
    end else if (E_icode == 4'h6 && !cc_inhibit) begin
      ZF <= new_zf;
      SF <= new_sf;
      OF <= new_of;
    end
  end

  // Condition uses the registered CC, i.e. flags of the previous OPq.
  assign sxo = SF ^ OF;

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      4'h0:    e_Cnd = 1'b1;
      4'h1:    e_Cnd = sxo | ZF;
      4'h2:    e_Cnd = sxo;
      4'h3:    e_Cnd = ZF;
      4'h4:    e_Cnd = !ZF;
      4'h5:    e_Cnd = !sxo;
      4'h6:    e_Cnd = !sxo && !ZF;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = (E_icode == 4'h2 && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe with hand-computed expected values.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        cc_inhibit, M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd, ZF, SF, OF;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  execute_pipe #(.RNONE(4'hF), .INOP(4'h1)) dut (
    .clk(clk), .rst(rst),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .cc_inhibit(cc_inhibit), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .ZF(ZF), .SF(SF), .OF(OF),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
    check({tag, ".ZF"}, {63'd0, ZF}, {63'd0, z});
    check({tag, ".SF"}, {63'd0, SF}, {63'd0, s});
    check({tag, ".OF"}, {63'd0, OF}, {63'd0, o});
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm);
    E_icode = icode; E_ifun = ifun;
    E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = de; E_dstM = dm;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cc_inhibit = 1'b0; M_bubble = 1'b0;
    set_e(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2, 4'h5);
    step(); step();
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    check("reset.M_icode", M_icode, 64'h1);
    check("reset.M_dstE", M_dstE, 64'hF);
    check("reset.M_dstM", M_dstM, 64'hF);
    check("reset.M_valE", M_valE, 64'h0);
    rst = 1'b0;

    // Signed overflow on add
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF);
    check("add.e_valE", e_valE, 64'h8000_0000_0000_0000);
    check("add.e_dstE", e_dstE, 64'h2);
    step();
    check_cc("add", 1'b0, 1'b1, 1'b1);
    check("add.M_valE", M_valE, 64'h8000_0000_0000_0000);
    check("add.M_icode", M_icode, 64'h6);
    check("add.M_valA", M_valA, 64'h7FFF_FFFF_FFFF_FFFF);
    check("add.M_dstE", M_dstE, 64'h2);

    // sub 5-5; le under CC(0,1,1) is false
    set_e(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
    check("sub.e_valE", e_valE, 64'h0);
    check("sub.e_Cnd_oldcc", {63'd0, e_Cnd}, 64'h0);
    step();
    check_cc("sub", 1'b1, 1'b0, 1'b0);

    set_e(4'h2, 4'h1, 64'h33, 64'd0, 64'd0, 4'h3, 4'hF);
    check("cmovle.e_Cnd", {63'd0, e_Cnd}, 64'h1);
    check("cmovle.e_dstE", e_dstE, 64'h3);
    check("cmovle.e_valE", e_valE, 64'h33);

    // Force CC to 0,0,0 with 1+1
    set_e(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h4, 4'hF);
    step();
    check_cc("add2", 1'b0, 1'b0, 1'b0);
    set_e(4'h2, 4'h1, 64'h33, 64'd0, 64'd0, 4'h3, 4'hF);
    check("cmovle0.e_Cnd", {63'd0, e_Cnd}, 64'h0);
    check("cmovle0.e_dstE", e_dstE, 64'hF);
    step();
    check("cmovle0.M_dstE", M_dstE, 64'hF);
    check("cmovle0.M_Cnd", {63'd0, M_Cnd}, 64'h0);
    set_e(4'h2, 4'h4, 64'h33, 64'd0, 64'd0, 4'h3, 4'hF);
    check("cmovne.e_dstE", e_dstE, 64'h3);

    // sub overflow: 0x8000..0 - 1
    set_e(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 4'hF);
    check("subov.e_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    check_cc("subov", 1'b0, 1'b0, 1'b1);
    set_e(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jl.e_Cnd", {63'd0, e_Cnd}, 64'h1);
    set_e(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jge.e_Cnd", {63'd0, e_Cnd}, 64'h0);
    set_e(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jg.e_Cnd", {63'd0, e_Cnd}, 64'h0);
    set_e(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    check("ifun7.e_Cnd", {63'd0, e_Cnd}, 64'h0);

    // Stack ops and misc icodes leave CC at 0,0,1
    set_e(4'hA, 4'h0, 64'h77, 64'h100, 64'd0, 4'h4, 4'hF);
    check("pushq.e_valE", e_valE, 64'hF8);
    step();
    set_e(4'h8, 4'h0, 64'd0, 64'h100, 64'h400, 4'h4, 4'hF);
    check("call.e_valE", e_valE, 64'hF8);
    step();
    set_e(4'hB, 4'h0, 64'hF8, 64'hF8, 64'd0, 4'h4, 4'h3);
    check("popq.e_valE", e_valE, 64'h100);
    step();
    set_e(4'h9, 4'h0, 64'hF8, 64'hF8, 64'd0, 4'h4, 4'hF);
    check("ret.e_valE", e_valE, 64'h100);
    step();
    set_e(4'h3, 4'h0, 64'd9, 64'd9, 64'h1234, 4'h5, 4'hF);
    check("irmovq.e_valE", e_valE, 64'h1234);
    step();
    set_e(4'hC, 4'h0, 64'h55, 64'h66, 64'h77, 4'h5, 4'h6);
    check("icodeC.e_valE", e_valE, 64'h0);
    step();
    check("icodeC.M_icode", M_icode, 64'hC);
    check("icodeC.M_valA", M_valA, 64'h55);
    check("icodeC.M_dstM", M_dstM, 64'h6);
    check_cc("stack", 1'b0, 1'b0, 1'b1);

    set_e(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 4'h2, 4'hF);
    check("and.e_valE", e_valE, 64'h30);
    set_e(4'h6, 4'h7, 64'hF0, 64'h3C, 64'd0, 4'h2, 4'hF);
    check("op7.e_valE", e_valE, 64'h0);

    // Inhibited xor: CC holds
    cc_inhibit = 1'b1;
    set_e(4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 4'h2, 4'hF);
    check("xor.e_valE", e_valE, 64'h0);
    step();
    cc_inhibit = 1'b0;
    check_cc("xorinh", 1'b0, 1'b0, 1'b1);
    check("xorinh.M_valE", M_valE, 64'h0);
    check("xorinh.M_icode", M_icode, 64'h6);

    // Bubble with OPq: CC still updates
    M_bubble = 1'b1;
    set_e(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'h3);
    step();
    M_bubble = 1'b0;
    check("bub.M_icode", M_icode, 64'h1);
    check("bub.M_dstE", M_dstE, 64'hF);
    check("bub.M_dstM", M_dstM, 64'hF);
    check("bub.M_valE", M_valE, 64'h0);
    check("bub.M_valA", M_valA, 64'h0);
    check("bub.M_Cnd", {63'd0, M_Cnd}, 64'h0);
    check_cc("bub", 1'b1, 1'b0, 1'b0);

    // Reset mid-stream
    set_e(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
    step();
    check_cc("pre_rst", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cc_inhibit = 1'b1;
    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF);
    check("rst.e_valE", e_valE, 64'h8000_0000_0000_0000);
    step();
    rst = 1'b0;
    cc_inhibit = 1'b0;
    check_cc("midrst", 1'b1, 1'b0, 1'b0);
    check("midrst.M_icode", M_icode, 64'h1);
    check("midrst.M_dstE", M_dstE, 64'hF);

    set_e(4'h5, 4'h0, 64'd0, 64'h20, 64'd8, 4'hF, 4'h4);
    step();
    check("mrmovq.M_valE", M_valE, 64'h28);
    check("mrmovq.M_icode", M_icode, 64'h5);
    check("mrmovq.M_dstM", M_dstM, 64'h4);
    check_cc("mrmovq", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
